// File: rtl/dump_mem_datos_ctrl.sv
// -----------------------------------------------------------------------------
// dump_mem_datos_ctrl
//
// Arbiter and sequencer for the data memory port.
//
// While idle the CPU MEM stage owns the memory port and its address / write
// enable pass straight through. A start pulse from the debug unit (CPU halted)
// hands the port to this block. It then scans every word 0..RAM_DEPTH-1 and,
// for each word whose dirty bit is set, sends a 6-byte record over the UART
// transmit handshake:
//     {addr[15:8], addr[7:0], data[31:24], data[23:16], data[15:8], data[7:0]}
// where the address is zero-extended to 16 bits. The scan is closed by the
// 2-byte marker 0xFF,0xFF, which can never be a valid address. A one-cycle
// o_done pulse follows, and the port is returned to the CPU.
//
// Ports
//   i_clock      clock
//   i_reset      asynchronous reset, active low (aborts a dump immediately)
//   i_start      dump request pulse, honoured only while idle
//   i_cpu_addr   CPU address, forwarded while idle
//   i_cpu_wea    CPU write enable, forwarded while idle, masked while busy
//   i_dato_mem   memory read data, READ_LATENCY cycles after o_addr_mem
//   i_bit_sucio  dirty bit of the addressed word, same latency as the data
//   i_tx_done    one-cycle pulse: UART finished the outstanding byte
//   o_addr_mem   memory address (CPU address or scan address)
//   o_wea_mem    memory write enable (CPU enable or 0)
//   o_tx_start   one-cycle pulse: transmit o_data_tx
//   o_data_tx    byte to transmit, stable until i_tx_done
//   o_busy       dump in progress, CPU must stall
//   o_done       one-cycle pulse once the end marker is acknowledged
// -----------------------------------------------------------------------------
module dump_mem_datos_ctrl #(
    parameter int RAM_DEPTH          = 1024,
    parameter int ADDR_LENGTH        = 10,
    parameter int RAM_WIDTH          = 32,
    parameter int OUTPUT_WORD_LENGTH = 8,
    parameter int READ_LATENCY       = 1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [ADDR_LENGTH-1:0]        i_cpu_addr,
    input  logic                          i_cpu_wea,
    input  logic [RAM_WIDTH-1:0]          i_dato_mem,
    input  logic                          i_bit_sucio,
    input  logic                          i_tx_done,
    output logic [ADDR_LENGTH-1:0]        o_addr_mem,
    output logic                          o_wea_mem,
    output logic                          o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0] o_data_tx,
    output logic                          o_busy,
    output logic                          o_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_SEND,
        S_WAIT,
        S_NEXT,
        S_MSEND,
        S_MWAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(RAM_DEPTH - 1);
    localparam logic [3:0]             LAT_LAST  = 4'(READ_LATENCY - 1);

    state_t                  r_state;
    logic [ADDR_LENGTH-1:0]  r_addr;
    logic [2:0]              r_bcnt;
    logic [3:0]              r_lat;
    logic [RAM_WIDTH-1:0]    r_data;

    state_t                  w_state_nxt;
    logic [ADDR_LENGTH-1:0]  w_addr_nxt;
    logic [2:0]              w_bcnt_nxt;
    logic [3:0]              w_lat_nxt;
    logic [RAM_WIDTH-1:0]    w_data_nxt;

    // Byte idx of the record for word addr holding data.
    function automatic logic [OUTPUT_WORD_LENGTH-1:0] f_rec_byte(
        input logic [2:0]             idx,
        input logic [ADDR_LENGTH-1:0] addr,
        input logic [RAM_WIDTH-1:0]   data
    );
        logic [15:0]                   a16;
        logic [OUTPUT_WORD_LENGTH-1:0] b;
        a16 = 16'(addr);
        case (idx)
            3'd0:    b = OUTPUT_WORD_LENGTH'(a16[15:8]);
            3'd1:    b = OUTPUT_WORD_LENGTH'(a16[7:0]);
            3'd2:    b = OUTPUT_WORD_LENGTH'(data[31:24]);
            3'd3:    b = OUTPUT_WORD_LENGTH'(data[23:16]);
            3'd4:    b = OUTPUT_WORD_LENGTH'(data[15:8]);
            default: b = OUTPUT_WORD_LENGTH'(data[7:0]);
        endcase
        return b;
    endfunction

    // Port mux: the scan owns the port exactly while o_busy is high.
    assign o_addr_mem = o_busy ? r_addr : i_cpu_addr;
    assign o_wea_mem  = o_busy ? 1'b0   : i_cpu_wea;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_bcnt_nxt  = r_bcnt;
        w_lat_nxt   = r_lat;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_READ;
                    w_addr_nxt  = '0;
                    w_lat_nxt   = '0;
                end
            end
            S_READ: begin
                if (r_lat == LAT_LAST) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_lat_nxt = r_lat + 4'd1;
                end
            end
            S_CHECK: begin
                w_data_nxt = i_dato_mem;
                if (i_bit_sucio) begin
                    w_state_nxt = S_SEND;
                    w_bcnt_nxt  = '0;
                end else begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_SEND: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_tx_done) begin
                    if (r_bcnt == 3'd5) begin
                        w_state_nxt = S_NEXT;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + 3'd1;
                        w_state_nxt = S_SEND;
                    end
                end
            end
            S_NEXT: begin
                // Stop at the last word; the address never wraps.
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = S_MSEND;
                    w_bcnt_nxt  = '0;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                    w_lat_nxt   = '0;
                    w_state_nxt = S_READ;
                end
            end
            S_MSEND: w_state_nxt = S_MWAIT;
            S_MWAIT: begin
                if (i_tx_done) begin
                    if (r_bcnt == 3'd1) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + 3'd1;
                        w_state_nxt = S_MSEND;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is valid for
    // exactly the cycles the FSM spends in the matching state.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_bcnt     <= '0;
            r_lat      <= '0;
            r_data     <= '0;
            o_tx_start <= 1'b0;
            o_data_tx  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_lat      <= w_lat_nxt;
            r_data     <= w_data_nxt;
            o_tx_start <= (w_state_nxt == S_SEND) || (w_state_nxt == S_MSEND);
            o_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            o_done     <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_SEND) begin
                o_data_tx <= f_rec_byte(w_bcnt_nxt, w_addr_nxt, w_data_nxt);
            end else if (w_state_nxt == S_MSEND) begin
                o_data_tx <= '1;
            end
        end
    end

endmodule

// File: tb/tb_dump_mem_datos_ctrl.sv
module tb_dump_mem_datos_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset;
    logic        i_start;
    logic [9:0]  i_cpu_addr;
    logic        i_cpu_wea;
    logic [31:0] i_dato_mem;
    logic        i_bit_sucio;
    logic        i_tx_done;
    logic [9:0]  o_addr_mem;
    logic        o_wea_mem;
    logic        o_tx_start;
    logic [7:0]  o_data_tx;
    logic        o_busy;
    logic        o_done;

    dump_mem_datos_ctrl dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wea   (i_cpu_wea),
        .i_dato_mem  (i_dato_mem),
        .i_bit_sucio (i_bit_sucio),
        .i_tx_done   (i_tx_done),
        .o_addr_mem  (o_addr_mem),
        .o_wea_mem   (o_wea_mem),
        .o_tx_start  (o_tx_start),
        .o_data_tx   (o_data_tx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    // Synchronous-read data memory with a dirty bit per word (latency 1).
    logic [31:0] mem_data  [DEPTH];
    logic        mem_dirty [DEPTH];
    int          wr_cnt = 0;
    always @(posedge clk) begin
        i_dato_mem  <= mem_data[o_addr_mem];
        i_bit_sucio <= mem_dirty[o_addr_mem];
        if (o_wea_mem === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART responder: accepts a byte on o_tx_start, answers i_tx_done after
    // resp_delay cycles; optionally injects stray i_tx_done pulses while idle.
    logic [7:0] rx_q[$];
    int         resp_delay = 3;
    bit         spur_en    = 1'b0;
    bit         pending    = 1'b0;
    logic [7:0] cap;
    int         cnt;

    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (i_reset !== 1'b1) begin
                pending = 1'b0;
            end else if (pending) begin
                check("tx_overlap", {31'd0, o_tx_start}, 32'd0);
                if (cnt == 0) begin
                    check("tx_stable", {24'd0, o_data_tx}, {24'd0, cap});
                    i_tx_done = 1'b1;
                    pending   = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (o_tx_start === 1'b1) begin
                cap = o_data_tx;
                rx_q.push_back(o_data_tx);
                pending = 1'b1;
                cnt     = resp_delay;
            end else if (spur_en && $urandom_range(0, 5) == 0) begin
                i_tx_done = 1'b1;
            end
        end
    end

    typedef struct {
        int          nd;
        logic [9:0]  a [2];
        logic [31:0] d [2];
        int          nb;
        logic [7:0]  b [14];
    } scen_t;
    scen_t vec [3];

    typedef struct {
        logic [9:0] cpu_addr;
        logic       cpu_wea;
        logic [9:0] exp_addr;
        logic       exp_wea;
    } mux_t;
    mux_t mvec [4];

    task automatic load_mem(input int s);
        for (int i = 0; i < DEPTH; i++) begin
            mem_data[i]  = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            mem_dirty[i] = 1'b0;
        end
        for (int k = 0; k < vec[s].nd; k++) begin
            mem_data[vec[s].a[k]]  = vec[s].d[k];
            mem_dirty[vec[s].a[k]] = 1'b1;
        end
    endtask

    task automatic wait_done(input string tag, output bit got);
        got = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    endtask

    task automatic run_dump(input int s, input bit noisy, input string tag);
        bit got;
        rx_q.delete();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check({tag, "_busy_on"}, {31'd0, o_busy}, 32'd1);
        check({tag, "_scan_addr0"}, {22'd0, o_addr_mem}, 32'd0);
        got = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                got = 1'b1;
                break;
            end
            i_start = noisy && (c % 400 == 7);
        end
        i_start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, "_busy_at_done"}, {31'd0, o_busy}, 32'd0);
            @(negedge clk);
            check({tag, "_done_1cyc"}, {31'd0, o_done}, 32'd0);
        end
        check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(vec[s].nb));
        for (int i = 0; i < vec[s].nb; i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD_0000,
                  {24'd0, vec[s].b[i]});
        end
    endtask

    initial begin
        bit got;
        int w0;
        string nm;

        vec[0].nd = 0;
        vec[0].a  = '{10'd0, 10'd0};
        vec[0].d  = '{32'd0, 32'd0};
        vec[0].nb = 2;
        vec[0].b  = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vec[1].nd = 1;
        vec[1].a  = '{10'd5, 10'd0};
        vec[1].d  = '{32'hDEAD_BEEF, 32'd0};
        vec[1].nb = 8;
        vec[1].b  = '{8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF,
                      8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vec[2].nd = 2;
        vec[2].a  = '{10'd0, 10'd1023};
        vec[2].d  = '{32'h0000_0001, 32'h8000_0000};
        vec[2].nb = 14;
        vec[2].b  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03,
                      8'hFF, 8'h80, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};

        mvec[0] = '{10'd0,   1'b0, 10'd0,   1'b0};
        mvec[1] = '{10'd7,   1'b1, 10'd7,   1'b1};
        mvec[2] = '{10'd1023, 1'b1, 10'd1023, 1'b1};
        mvec[3] = '{10'h2AA, 1'b0, 10'h2AA, 1'b0};

        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_cpu_addr = 10'h155;
        i_cpu_wea  = 1'b0;
        load_mem(0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",     {31'd0, o_busy},     32'd0);
        check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
        check("rst_data_tx",  {24'd0, o_data_tx},  32'd0);
        check("rst_done",     {31'd0, o_done},     32'd0);
        check("rst_mux_addr", {22'd0, o_addr_mem}, 32'h155);
        i_reset = 1'b1;

        // Idle pass-through
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_cpu_addr = mvec[i].cpu_addr;
            i_cpu_wea  = mvec[i].cpu_wea;
            #1;
            check($sformatf("mux%0d_addr", i), {22'd0, o_addr_mem}, {22'd0, mvec[i].exp_addr});
            check($sformatf("mux%0d_wea", i),  {31'd0, o_wea_mem},  {31'd0, mvec[i].exp_wea});
        end
        i_cpu_wea = 1'b0;

        // Table dumps: no dirty words, one word, first and last words
        for (int s = 0; s < 3; s++) begin
            load_mem(s);
            nm = $sformatf("dump%0d", s);
            run_dump(s, 1'b0, nm);
        end

        // CPU writes masked and scan address on the port during a dump
        load_mem(0);
        i_cpu_addr = 10'd7;
        i_cpu_wea  = 1'b1;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        w0 = wr_cnt;
        for (int n = 1; n <= 40; n++) begin
            check($sformatf("mask_wea_n%0d", n), {31'd0, o_wea_mem}, 32'd0);
            if (n == 1 || n == 4 || n == 31)
                check($sformatf("scan_addr_n%0d", n), {22'd0, o_addr_mem}, 32'((n - 1) / 3));
            @(negedge clk);
        end
        wait_done("mask", got);
        check("mask_no_writes", 32'(wr_cnt), 32'(w0));
        @(negedge clk);
        check("mask_idle_addr", {22'd0, o_addr_mem}, 32'd7);
        check("mask_idle_wea",  {31'd0, o_wea_mem},  32'd1);
        i_cpu_wea  = 1'b0;
        i_cpu_addr = 10'd3;

        // Reset while waiting on the third record byte
        load_mem(1);
        rx_q.delete();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (rx_q.size() >= 3) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_reach_byte3", {31'd0, got}, 32'd1);
        @(negedge clk);
        #2 i_reset = 1'b0;
        #1;
        check("abort_tx_start", {31'd0, o_tx_start}, 32'd0);
        check("abort_busy",     {31'd0, o_busy},     32'd0);
        check("abort_done",     {31'd0, o_done},     32'd0);
        check("abort_mux_addr", {22'd0, o_addr_mem}, 32'd3);
        repeat (2) @(negedge clk);
        #2 i_reset = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_busy === 1'b1 || o_tx_start === 1'b1) got = 1'b1;
        end
        check("abort_stays_idle", {31'd0, got}, 32'd0);
        run_dump(1, 1'b0, "restart");

        // Stray start and tx_done pulses during a dump
        spur_en = 1'b1;
        run_dump(1, 1'b1, "noisy");
        spur_en = 1'b0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
